observer_real_window_mon: RTL and testbench
===========================================

# observer_real_window_mon

Multi-channel clocked window monitor for real-valued analog nets in the analog UVM testbench. Each channel samples a real value every clock, checks it against a per-channel inclusive window and an upper threshold, and tracks settling, debounced window violations and timeouts with a small per-channel state machine. Registered flags and counters feed observer proxies and scoreboards, so checks do not depend on raw `always @(value)` sensitivity.

## Interface
- N_CH, 4, number of independent channels
- CNT_W, 16, width of per-channel counters (settle time, violation count)
- SETTLE_CYCLES, 4, consecutive in-window samples needed to declare settled (>=1)
- DEBOUNCE, 3, consecutive out-of-window samples needed to declare a violation (>=1)
- TIMEOUT, 1000, max cycles allowed in SETTLING before a timeout (< 2^CNT_W)
- clk  in  1  sample clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- observed_value  in  real[N_CH]  sampled analog values
- win_min, win_max  in  real[N_CH]  inclusive window bounds; win_min <= win_max required
- threshold  in  real[N_CH]  upper threshold for `above`
- enable  in  [N_CH]  per-channel enable; level-sensitive
- clear  in  1  synchronous pulse: clears sticky flags and violation counts on all channels
- in_window  out  [N_CH]  registered win_min <= value <= win_max
- above  out  [N_CH]  registered value > threshold (strict)
- settled  out  [N_CH]  high while channel is in SETTLED
- violation  out  [N_CH]  sticky; set on entry to VIOLATED from SETTLED
- timeout  out  [N_CH]  sticky; set on SETTLING timeout
- viol_count  out  [N_CH][CNT_W]  saturating count of SETTLED->VIOLATED transitions
- settle_time  out  [N_CH][CNT_W]  cycles from enable to first settled, latched per enable

## Operation
- Per-channel states: DISABLED, SETTLING, SETTLED, VIOLATED. Counters: elapsed, in_run, out_run.
- enable=0 in any state -> DISABLED next cycle; elapsed/in_run/out_run cleared; sticky flags, viol_count, settle_time retained.
- DISABLED, enable=1 -> SETTLING; elapsed=0, in_run=0.
- SETTLING: elapsed+1 each cycle (saturating at 2^CNT_W-1); in_run+1 if in-window else 0. in_run reaches SETTLE_CYCLES -> SETTLED, settle_time<=elapsed of that cycle. Otherwise elapsed reaches TIMEOUT -> VIOLATED, timeout<=1. Settling has priority over timeout in the same cycle.
- SETTLED: out_run+1 when out of window, 0 when in window. out_run reaches DEBOUNCE -> VIOLATED, violation<=1, viol_count+1 (saturates at all-ones).
- VIOLATED: in_run counts in-window samples; reaching SETTLE_CYCLES -> SETTLED, out_run=0. Sticky flags stay set.
- clear: zeroes violation, timeout and viol_count on all channels; does not change state or settle_time. clear with a same-cycle increment gives viol_count=1 and violation=1. Set wins over clear.
- Inverted bounds (win_min > win_max): in_window stays 0. Not an error.
- A NaN or X-equivalent real compares false: not in window, not above.

## Timing
- Reset: state DISABLED; every output and internal counter 0.
- in_window/above: one cycle latency from the sampled value.
- A value entering the window at edge k gives settled=1 at edge k+SETTLE_CYCLES, with enable already high and SETTLING active.
- A value leaving the window at edge k gives violation=1 at edge k+DEBOUNCE.
- settle_time counts edges from the first SETTLING cycle. Minimum value is SETTLE_CYCLES-1 when the value is in window from enable.
- rst mid-operation overrides enable and clear in the same cycle. Reset applies to all channels; channels are otherwise fully independent.

## Test plan
- Ch0 window [0.9,1.1], value 1.0 steady, enable at cycle 10 -> settled=1 at cycle 14, settle_time=3, no flags.
- Ch1 settled; value 1.5 for 2 cycles then 1.0 -> no violation. Value 1.5 for 3 cycles -> violation=1, viol_count=1. Back to 1.0 for 4 cycles -> settled=1, violation stays 1.
- Ch2 value 0.0 never in window, TIMEOUT=1000 -> timeout=1 and state VIOLATED exactly 1000 cycles after enable. Ch0/ch1 unaffected.
- Boundary: value equal to win_min, win_max and threshold -> in_window=1, above=0. Value threshold+1e-9 -> above=1.
- clear asserted in the same cycle as the 3rd out-of-window sample -> viol_count=1, violation=1. clear alone afterwards -> both 0, state unchanged.
- rst asserted while in SETTLED with viol_count=5 -> next cycle all outputs 0, state DISABLED. With enable still high, SETTLING starts the cycle after rst drops.

Source files
------------

// File: rtl/observer_real_window_mon_if.sv
// Bus between the analog testbench and the real-valued window monitor:
// sampled values and window bounds in, registered per-channel flags and counters out.
interface observer_real_window_mon_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
);
  real                        i_observed_value [N_CH];
  real                        i_win_min        [N_CH];
  real                        i_win_max        [N_CH];
  real                        i_threshold      [N_CH];
  logic [N_CH-1:0]            i_enable;
  logic                       i_clear;
  logic [N_CH-1:0]            o_in_window;
  logic [N_CH-1:0]            o_above;
  logic [N_CH-1:0]            o_settled;
  logic [N_CH-1:0]            o_violation;
  logic [N_CH-1:0]            o_timeout;
  logic [N_CH-1:0][CNT_W-1:0] o_viol_count;
  logic [N_CH-1:0][CNT_W-1:0] o_settle_time;

  modport master (
    output i_observed_value, i_win_min, i_win_max, i_threshold, i_enable, i_clear,
    input  o_in_window, o_above, o_settled, o_violation, o_timeout, o_viol_count, o_settle_time
  );

  modport slave (
    input  i_observed_value, i_win_min, i_win_max, i_threshold, i_enable, i_clear,
    output o_in_window, o_above, o_settled, o_violation, o_timeout, o_viol_count, o_settle_time
  );
endinterface

// File: rtl/observer_real_window_mon.sv
// Multi-channel clocked window monitor for real-valued nets: per-channel settle,
// debounced violation and settling-timeout tracking with registered flags and counters.
module observer_real_window_ch #(
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int DEBOUNCE      = 3,
  parameter int TIMEOUT       = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  real              i_value,
  input  real              i_win_min,
  input  real              i_win_max,
  input  real              i_threshold,
  input  logic             i_enable,
  input  logic             i_clear,
  output logic             o_in_window,
  output logic             o_above,
  output logic             o_settled,
  output logic             o_violation,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_viol_count,
  output logic [CNT_W-1:0] o_settle_time
);
  typedef enum logic [1:0] {ST_DISABLED, ST_SETTLING, ST_SETTLED, ST_VIOLATED} state_t;

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETTLE_N   = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] DEBOUNCE_N = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] TIMEOUT_N  = CNT_W'(TIMEOUT);

  state_t           r_state;
  logic             r_in_window, r_above, r_settled, r_violation, r_timeout;
  logic [CNT_W-1:0] r_elapsed, r_in_run, r_out_run, r_viol_count, r_settle_time;

  logic             w_in_cmp, w_above_cmp;
  logic             w_settle_hit, w_timeout_hit, w_debounce_hit, w_recover_hit;
  logic [CNT_W-1:0] w_elapsed_inc, w_in_run_inc, w_out_run_inc, w_viol_inc;

  // Real compares are false for NaN and for inverted bounds, so both read as out of window.
  // The state machine runs on the registered window flag, one sample behind the input.
  always_comb begin
    w_in_cmp       = (i_value >= i_win_min) && (i_value <= i_win_max);
    w_above_cmp    = i_value > i_threshold;
    w_elapsed_inc  = (&r_elapsed) ? r_elapsed : r_elapsed + ONE;
    w_in_run_inc   = r_in_run + ONE;
    w_out_run_inc  = r_out_run + ONE;
    w_viol_inc     = (&r_viol_count) ? r_viol_count : r_viol_count + ONE;
    w_settle_hit   = i_enable && (r_state == ST_SETTLING) && r_in_window &&
                     (w_in_run_inc == SETTLE_N);
    w_timeout_hit  = i_enable && (r_state == ST_SETTLING) && !w_settle_hit &&
                     (w_elapsed_inc == TIMEOUT_N);
    w_debounce_hit = i_enable && (r_state == ST_SETTLED) && !r_in_window &&
                     (w_out_run_inc == DEBOUNCE_N);
    w_recover_hit  = i_enable && (r_state == ST_VIOLATED) && r_in_window &&
                     (w_in_run_inc == SETTLE_N);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_DISABLED;
      r_in_window   <= 1'b0;
      r_above       <= 1'b0;
      r_settled     <= 1'b0;
      r_violation   <= 1'b0;
      r_timeout     <= 1'b0;
      r_elapsed     <= '0;
      r_in_run      <= '0;
      r_out_run     <= '0;
      r_viol_count  <= '0;
      r_settle_time <= '0;
    end else begin
      r_in_window <= w_in_cmp;
      r_above     <= w_above_cmp;
      // Sticky flags: a same-cycle set beats clear.
      r_violation <= w_debounce_hit | (r_violation & ~i_clear);
      r_timeout   <= w_timeout_hit | (r_timeout & ~i_clear);
      if (i_clear)
        r_viol_count <= w_debounce_hit ? ONE : '0;
      else if (w_debounce_hit)
        r_viol_count <= w_viol_inc;

      if (!i_enable) begin
        r_state   <= ST_DISABLED;
        r_settled <= 1'b0;
        r_elapsed <= '0;
        r_in_run  <= '0;
        r_out_run <= '0;
      end else begin
        case (r_state)
          ST_DISABLED: begin
            r_state   <= ST_SETTLING;
            r_elapsed <= '0;
            r_in_run  <= '0;
            r_out_run <= '0;
          end
          ST_SETTLING: begin
            r_elapsed <= w_elapsed_inc;
            r_in_run  <= r_in_window ? w_in_run_inc : '0;
            if (w_settle_hit) begin
              r_state       <= ST_SETTLED;
              r_settled     <= 1'b1;
              r_settle_time <= r_elapsed;
              r_in_run      <= '0;
              r_out_run     <= '0;
            end else if (w_timeout_hit) begin
              r_state  <= ST_VIOLATED;
              r_in_run <= '0;
            end
          end
          ST_SETTLED: begin
            r_out_run <= r_in_window ? '0 : w_out_run_inc;
            if (w_debounce_hit) begin
              r_state   <= ST_VIOLATED;
              r_settled <= 1'b0;
              r_out_run <= '0;
              r_in_run  <= '0;
            end
          end
          ST_VIOLATED: begin
            r_in_run <= r_in_window ? w_in_run_inc : '0;
            if (w_recover_hit) begin
              r_state   <= ST_SETTLED;
              r_settled <= 1'b1;
              r_in_run  <= '0;
              r_out_run <= '0;
            end
          end
          default: r_state <= ST_DISABLED;
        endcase
      end
    end
  end

  assign o_in_window   = r_in_window;
  assign o_above       = r_above;
  assign o_settled     = r_settled;
  assign o_violation   = r_violation;
  assign o_timeout     = r_timeout;
  assign o_viol_count  = r_viol_count;
  assign o_settle_time = r_settle_time;
endmodule

module observer_real_window_mon #(
  parameter int N_CH          = 4,
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int DEBOUNCE      = 3,
  parameter int TIMEOUT       = 1000
) (
  input logic                  clk,
  input logic                  rst,
  observer_real_window_mon_if.slave bus
);
  logic [N_CH-1:0]            w_in_window, w_above, w_settled, w_violation, w_timeout;
  logic [N_CH-1:0][CNT_W-1:0] w_viol_count, w_settle_time;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    observer_real_window_ch #(
      .CNT_W        (CNT_W),
      .SETTLE_CYCLES(SETTLE_CYCLES),
      .DEBOUNCE     (DEBOUNCE),
      .TIMEOUT      (TIMEOUT)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .i_value      (bus.i_observed_value[g]),
      .i_win_min    (bus.i_win_min[g]),
      .i_win_max    (bus.i_win_max[g]),
      .i_threshold  (bus.i_threshold[g]),
      .i_enable     (bus.i_enable[g]),
      .i_clear      (bus.i_clear),
      .o_in_window  (w_in_window[g]),
      .o_above      (w_above[g]),
      .o_settled    (w_settled[g]),
      .o_violation  (w_violation[g]),
      .o_timeout    (w_timeout[g]),
      .o_viol_count (w_viol_count[g]),
      .o_settle_time(w_settle_time[g])
    );
  end

  assign bus.o_in_window   = w_in_window;
  assign bus.o_above       = w_above;
  assign bus.o_settled     = w_settled;
  assign bus.o_violation   = w_violation;
  assign bus.o_timeout     = w_timeout;
  assign bus.o_viol_count  = w_viol_count;
  assign bus.o_settle_time = w_settle_time;
endmodule

// File: tb/tb_observer_real_window_mon.sv
// Bench for observer_real_window_mon: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the channel rules.
module tb_observer_real_window_mon;
  localparam int N    = 4;
  localparam int CW   = 16;
  localparam int SC   = 4;
  localparam int DEB  = 3;
  localparam int TO   = 1000;
  localparam int MAXC = (1 << CW) - 1;
  localparam int S_DIS = 0, S_SETTLING = 1, S_SET = 2, S_VIOL = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  observer_real_window_mon_if #(.N_CH(N), .CNT_W(CW)) bus ();

  observer_real_window_mon #(
    .N_CH(N), .CNT_W(CW), .SETTLE_CYCLES(SC), .DEBOUNCE(DEB), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int m_st[N], m_el[N], m_in[N], m_out[N], m_vc[N], m_stime[N];
  bit m_inw[N], m_ab[N], m_viol[N], m_to[N];

  // Applies one clock edge of the channel rules to the model using the inputs seen at that edge.
  task automatic model_step();
    bit  seen, vs, ts;
    int  e;
    real v;
    for (int c = 0; c < N; c++) begin
      if (rst) begin
        m_st[c] = S_DIS; m_el[c] = 0; m_in[c] = 0; m_out[c] = 0; m_vc[c] = 0;
        m_stime[c] = 0; m_inw[c] = 0; m_ab[c] = 0; m_viol[c] = 0; m_to[c] = 0;
        continue;
      end
      seen = m_inw[c]; vs = 0; ts = 0;
      v = bus.i_observed_value[c];
      m_inw[c] = (v >= bus.i_win_min[c]) && (v <= bus.i_win_max[c]);
      m_ab[c]  = v > bus.i_threshold[c];
      if (!bus.i_enable[c]) begin
        m_st[c] = S_DIS; m_el[c] = 0; m_in[c] = 0; m_out[c] = 0;
      end else if (m_st[c] == S_DIS) begin
        m_st[c] = S_SETTLING; m_el[c] = 0; m_in[c] = 0; m_out[c] = 0;
      end else if (m_st[c] == S_SETTLING) begin
        e = (m_el[c] < MAXC) ? m_el[c] + 1 : m_el[c];
        m_in[c] = seen ? m_in[c] + 1 : 0;
        if (m_in[c] == SC) begin
          m_st[c] = S_SET; m_stime[c] = m_el[c]; m_in[c] = 0; m_out[c] = 0;
        end else if (e == TO) begin
          m_st[c] = S_VIOL; ts = 1; m_in[c] = 0;
        end
        m_el[c] = e;
      end else if (m_st[c] == S_SET) begin
        m_out[c] = seen ? 0 : m_out[c] + 1;
        if (m_out[c] == DEB) begin
          m_st[c] = S_VIOL; vs = 1; m_out[c] = 0; m_in[c] = 0;
        end
      end else begin
        m_in[c] = seen ? m_in[c] + 1 : 0;
        if (m_in[c] == SC) begin
          m_st[c] = S_SET; m_in[c] = 0; m_out[c] = 0;
        end
      end
      if (bus.i_clear) begin m_viol[c] = 0; m_to[c] = 0; m_vc[c] = 0; end
      if (vs) begin
        m_viol[c] = 1;
        if (m_vc[c] < MAXC) m_vc[c] = m_vc[c] + 1;
      end
      if (ts) m_to[c] = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_ch(input int c, input real v, input real mn, input real mx, input real th);
    bus.i_observed_value[c] = v;
    bus.i_win_min[c] = mn;
    bus.i_win_max[c] = mx;
    bus.i_threshold[c] = th;
  endtask

  task automatic test_reset();
    for (int c = 0; c < N; c++) set_ch(c, 1.0, 0.9, 1.1, 1.05);
    bus.i_enable = '0;
    bus.i_clear  = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (bus.o_in_window !== '0) begin errors++; $display("FAIL reset_in_window got=%b exp=0", bus.o_in_window); end
    checks++; if (bus.o_above !== '0) begin errors++; $display("FAIL reset_above got=%b exp=0", bus.o_above); end
    checks++; if (bus.o_settled !== '0) begin errors++; $display("FAIL reset_settled got=%b exp=0", bus.o_settled); end
    checks++; if (bus.o_violation !== '0 || bus.o_timeout !== '0) begin errors++; $display("FAIL reset_flags got=%b/%b exp=0/0", bus.o_violation, bus.o_timeout); end
    checks++; if (bus.o_viol_count !== '0 || bus.o_settle_time !== '0) begin errors++; $display("FAIL reset_counts got=%h/%h exp=0/0", bus.o_viol_count, bus.o_settle_time); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_settle();
    tick();
    bus.i_enable[0] = 1'b1;
    tick();
    repeat (3) tick();
    checks++; if (bus.o_settled[0] !== 1'b0) begin errors++; $display("FAIL settle_early got=%b exp=0", bus.o_settled[0]); end
    tick();
    checks++; if (bus.o_settled[0] !== 1'b1) begin errors++; $display("FAIL settle_on_time got=%b exp=1", bus.o_settled[0]); end
    checks++; if (bus.o_settle_time[0] !== 16'd3) begin errors++; $display("FAIL settle_time got=%0d exp=3", bus.o_settle_time[0]); end
    checks++; if (bus.o_violation[0] !== 1'b0 || bus.o_timeout[0] !== 1'b0) begin errors++; $display("FAIL settle_noflags got=%b/%b exp=0/0", bus.o_violation[0], bus.o_timeout[0]); end
  endtask

  task automatic test_debounce();
    bus.i_enable[1] = 1'b1;
    repeat (6) tick();
    checks++; if (bus.o_settled[1] !== 1'b1) begin errors++; $display("FAIL deb_settled got=%b exp=1", bus.o_settled[1]); end
    bus.i_observed_value[1] = 1.5;
    repeat (2) tick();
    bus.i_observed_value[1] = 1.0;
    repeat (6) tick();
    checks++; if (bus.o_violation[1] !== 1'b0 || bus.o_settled[1] !== 1'b1) begin errors++; $display("FAIL deb_short_glitch got viol=%b settled=%b exp=0/1", bus.o_violation[1], bus.o_settled[1]); end
    bus.i_observed_value[1] = 1.5;
    repeat (2) tick();
    tick();
    checks++; if (bus.o_violation[1] !== 1'b0) begin errors++; $display("FAIL deb_early got=%b exp=0", bus.o_violation[1]); end
    bus.i_observed_value[1] = 1.0;
    tick();
    checks++; if (bus.o_violation[1] !== 1'b1 || bus.o_viol_count[1] !== 16'd1) begin errors++; $display("FAIL deb_violation got viol=%b cnt=%0d exp=1/1", bus.o_violation[1], bus.o_viol_count[1]); end
    checks++; if (bus.o_settled[1] !== 1'b0) begin errors++; $display("FAIL deb_left_settled got=%b exp=0", bus.o_settled[1]); end
    repeat (3) tick();
    checks++; if (bus.o_settled[1] !== 1'b0) begin errors++; $display("FAIL deb_recover_early got=%b exp=0", bus.o_settled[1]); end
    tick();
    checks++; if (bus.o_settled[1] !== 1'b1 || bus.o_violation[1] !== 1'b1) begin errors++; $display("FAIL deb_recover got settled=%b viol=%b exp=1/1", bus.o_settled[1], bus.o_violation[1]); end
  endtask

  task automatic test_timeout();
    bus.i_observed_value[2] = 0.0;
    bus.i_enable[2] = 1'b1;
    tick();
    repeat (TO - 1) tick();
    checks++; if (bus.o_timeout[2] !== 1'b0) begin errors++; $display("FAIL timeout_early got=%b exp=0", bus.o_timeout[2]); end
    tick();
    checks++; if (bus.o_timeout[2] !== 1'b1 || bus.o_settled[2] !== 1'b0) begin errors++; $display("FAIL timeout_fire got to=%b settled=%b exp=1/0", bus.o_timeout[2], bus.o_settled[2]); end
    checks++; if (bus.o_violation[2] !== 1'b0) begin errors++; $display("FAIL timeout_noviol got=%b exp=0", bus.o_violation[2]); end
    checks++; if (bus.o_settled[1:0] !== 2'b11 || bus.o_timeout[1:0] !== 2'b00) begin errors++; $display("FAIL timeout_isolation got settled=%b to=%b exp=11/00", bus.o_settled[1:0], bus.o_timeout[1:0]); end
  endtask

  task automatic test_boundary();
    real z, nan;
    set_ch(3, 0.9, 0.9, 1.1, 1.1);
    tick();
    checks++; if (bus.o_in_window[3] !== 1'b1 || bus.o_above[3] !== 1'b0) begin errors++; $display("FAIL bound_min got in=%b above=%b exp=1/0", bus.o_in_window[3], bus.o_above[3]); end
    bus.i_observed_value[3] = 1.1;
    tick();
    checks++; if (bus.o_in_window[3] !== 1'b1 || bus.o_above[3] !== 1'b0) begin errors++; $display("FAIL bound_max got in=%b above=%b exp=1/0", bus.o_in_window[3], bus.o_above[3]); end
    bus.i_observed_value[3] = 1.1 + 1e-9;
    tick();
    checks++; if (bus.o_in_window[3] !== 1'b0 || bus.o_above[3] !== 1'b1) begin errors++; $display("FAIL bound_above got in=%b above=%b exp=0/1", bus.o_in_window[3], bus.o_above[3]); end
    set_ch(3, 1.5, 2.0, 1.0, 1.1);
    tick();
    checks++; if (bus.o_in_window[3] !== 1'b0) begin errors++; $display("FAIL bound_inverted got=%b exp=0", bus.o_in_window[3]); end
    z = 0.0;
    nan = z / z;
    set_ch(3, nan, 0.9, 1.1, 1.1);
    tick();
    checks++; if (bus.o_in_window[3] !== 1'b0 || bus.o_above[3] !== 1'b0) begin errors++; $display("FAIL bound_nan got in=%b above=%b exp=0/0", bus.o_in_window[3], bus.o_above[3]); end
    bus.i_observed_value[3] = 1.0;
    tick();
  endtask

  task automatic test_clear();
    bus.i_clear = 1'b1;
    tick();
    bus.i_clear = 1'b0;
    checks++; if (bus.o_violation[1] !== 1'b0 || bus.o_viol_count[1] !== 16'd0 || bus.o_timeout[2] !== 1'b0) begin errors++; $display("FAIL clear_alone got viol=%b cnt=%0d to=%b exp=0/0/0", bus.o_violation[1], bus.o_viol_count[1], bus.o_timeout[2]); end
    checks++; if (bus.o_settled[1] !== 1'b1 || bus.o_settle_time[1] !== 16'd3) begin errors++; $display("FAIL clear_keeps_state got settled=%b st=%0d exp=1/3", bus.o_settled[1], bus.o_settle_time[1]); end
    bus.i_observed_value[1] = 1.5;
    repeat (3) tick();
    bus.i_observed_value[1] = 1.0;
    bus.i_clear = 1'b1;
    tick();
    bus.i_clear = 1'b0;
    checks++; if (bus.o_violation[1] !== 1'b1 || bus.o_viol_count[1] !== 16'd1) begin errors++; $display("FAIL clear_vs_set got viol=%b cnt=%0d exp=1/1", bus.o_violation[1], bus.o_viol_count[1]); end
    bus.i_clear = 1'b1;
    tick();
    bus.i_clear = 1'b0;
    checks++; if (bus.o_violation[1] !== 1'b0 || bus.o_viol_count[1] !== 16'd0 || bus.o_settled[1] !== 1'b0) begin errors++; $display("FAIL clear_in_violated got viol=%b cnt=%0d settled=%b exp=0/0/0", bus.o_violation[1], bus.o_viol_count[1], bus.o_settled[1]); end
    repeat (3) tick();
    checks++; if (bus.o_settled[1] !== 1'b1) begin errors++; $display("FAIL clear_recover got=%b exp=1", bus.o_settled[1]); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 5; k++) begin
      bus.i_observed_value[1] = 1.5;
      repeat (3) tick();
      bus.i_observed_value[1] = 1.0;
      repeat (5) tick();
    end
    checks++; if (bus.o_viol_count[1] !== 16'd5 || bus.o_settled[1] !== 1'b1) begin errors++; $display("FAIL rstmid_setup got cnt=%0d settled=%b exp=5/1", bus.o_viol_count[1], bus.o_settled[1]); end
    rst = 1'b1;
    bus.i_clear = 1'b1;
    tick();
    rst = 1'b0;
    bus.i_clear = 1'b0;
    checks++; if (bus.o_settled !== '0 || bus.o_violation !== '0 || bus.o_timeout !== '0 || bus.o_in_window !== '0 || bus.o_above !== '0) begin errors++; $display("FAIL rstmid_flags got s=%b v=%b t=%b i=%b a=%b exp=all0", bus.o_settled, bus.o_violation, bus.o_timeout, bus.o_in_window, bus.o_above); end
    checks++; if (bus.o_viol_count !== '0 || bus.o_settle_time !== '0) begin errors++; $display("FAIL rstmid_counts got %h/%h exp=0/0", bus.o_viol_count, bus.o_settle_time); end
    repeat (4) tick();
    checks++; if (bus.o_settled[1] !== 1'b0) begin errors++; $display("FAIL rstmid_early got=%b exp=0", bus.o_settled[1]); end
    tick();
    checks++; if (bus.o_settled[1] !== 1'b1 || bus.o_settle_time[1] !== 16'd3) begin errors++; $display("FAIL rstmid_resettle got settled=%b st=%0d exp=1/3", bus.o_settled[1], bus.o_settle_time[1]); end
  endtask

  task automatic test_random();
    real v;
    for (int c = 0; c < N; c++) set_ch(c, 1.0, 0.9, 1.1, 1.0);
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 99) < 78) v = 0.9 + 0.2 * real'($urandom_range(0, 1000)) / 1000.0;
        else v = 0.5 + real'($urandom_range(0, 1000)) / 1000.0;
        bus.i_observed_value[c] = v;
        if ($urandom_range(0, 59) == 0) bus.i_enable[c] = ~bus.i_enable[c];
      end
      bus.i_clear = ($urandom_range(0, 39) == 0);
      tick();
      for (int c = 0; c < N; c++) begin
        checks++; if (bus.o_in_window[c] !== m_inw[c]) begin errors++; $display("FAIL rand_in_window ch%0d cyc%0d got=%b exp=%b", c, cyc, bus.o_in_window[c], m_inw[c]); end
        checks++; if (bus.o_above[c] !== m_ab[c]) begin errors++; $display("FAIL rand_above ch%0d cyc%0d got=%b exp=%b", c, cyc, bus.o_above[c], m_ab[c]); end
        checks++; if (bus.o_settled[c] !== (m_st[c] == S_SET)) begin errors++; $display("FAIL rand_settled ch%0d cyc%0d got=%b exp=%b", c, cyc, bus.o_settled[c], m_st[c] == S_SET); end
        checks++; if (bus.o_violation[c] !== m_viol[c] || bus.o_timeout[c] !== m_to[c]) begin errors++; $display("FAIL rand_flags ch%0d cyc%0d got=%b/%b exp=%b/%b", c, cyc, bus.o_violation[c], bus.o_timeout[c], m_viol[c], m_to[c]); end
        checks++; if (bus.o_viol_count[c] !== CW'(m_vc[c])) begin errors++; $display("FAIL rand_viol_count ch%0d cyc%0d got=%0d exp=%0d", c, cyc, bus.o_viol_count[c], m_vc[c]); end
        checks++; if (bus.o_settle_time[c] !== CW'(m_stime[c])) begin errors++; $display("FAIL rand_settle_time ch%0d cyc%0d got=%0d exp=%0d", c, cyc, bus.o_settle_time[c], m_stime[c]); end
      end
    end
    bus.i_clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_settle();
    test_debounce();
    test_timeout();
    test_boundary();
    test_clear();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
